// File: rtl/lbist_ctrl.sv
// Logic BIST sequencer: seeds the LFSR, runs PATTERN_CNT patterns, flushes the MISR and
// compares the signature. Optional LBIST_SIG_OUT_EN exposes the captured signature on sig_o.
module lbist_ctrl #(
    parameter int unsigned      PATTERN_CNT = 256,
    parameter int unsigned      PIPE_DEPTH  = 2,
    parameter int unsigned      SIG_W       = 32,
    parameter logic [SIG_W-1:0] GOLDEN_SIG  = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [SIG_W-1:0] misr_sig_i,
    output logic             test_mode_o,
    output logic             lfsr_seed_load_o,
    output logic             lfsr_en_o,
    output logic             misr_clear_o,
    output logic             misr_en_o,
`ifdef LBIST_SIG_OUT_EN
    output logic [SIG_W-1:0] sig_o,
`endif
    output logic             done_o,
    output logic             go_nogo_o
);

    localparam int unsigned CntW = $clog2(PATTERN_CNT + 1);
    localparam int unsigned SetW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(PATTERN_CNT - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(PATTERN_CNT);
    localparam logic [SetW-1:0] SetLast = SetW'((PIPE_DEPTH > 0) ? PIPE_DEPTH - 1 : 0);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StRun,
        StSettle,
        StCompare,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic            start_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [SetW-1:0] set_q, set_d;
    logic            pass_q, pass_d;
    logic            start_edge;

    assign start_edge = start_i & ~start_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            start_q <= 1'b0;
            cnt_q   <= '0;
            set_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_i;
            cnt_q   <= cnt_d;
            set_q   <= set_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        set_d   = set_q;
        pass_d  = pass_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (start_edge) state_d = StInit;
            end
            StInit: begin
                cnt_d   = '0;
                set_d   = '0;
                state_d = StRun;
            end
            StRun: begin
                // Saturate so the counter can never wrap back into range.
                if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntLast) state_d = (PIPE_DEPTH > 0) ? StSettle : StCompare;
            end
            StSettle: begin
                set_d = set_q + SetW'(1);
                if (set_q == SetLast) state_d = StCompare;
            end
            StCompare: begin
                pass_d  = (misr_sig_i == GOLDEN_SIG);
                state_d = StDone;
            end
            StDone: begin
                if (!start_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Dropping the request aborts any active phase without a done pulse.
        if (!start_i && (state_q inside {StInit, StRun, StSettle, StCompare})) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        test_mode_o      = state_q inside {StInit, StRun, StSettle, StCompare};
        lfsr_seed_load_o = (state_q == StInit);
        misr_clear_o     = (state_q == StInit);
        lfsr_en_o        = (state_q == StRun);
        misr_en_o        = (state_q == StRun) || (state_q == StSettle);
        done_o           = (state_q == StDone);
        go_nogo_o        = (state_q == StDone) && pass_q;
    end

`ifdef LBIST_SIG_OUT_EN
    logic [SIG_W-1:0] sig_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sig_q <= '0;
        end else if (state_q == StCompare) begin
            sig_q <= misr_sig_i;
        end
    end

    assign sig_o = sig_q;
`endif

endmodule

// File: tb/tb_lbist_ctrl.sv
// Self-checking bench for lbist_ctrl: a run-position model predicts every output per cycle.
module tb_lbist_ctrl;

    localparam int          P      = 8;
    localparam int          D      = 2;
    localparam logic [31:0] Golden = 32'hDEADBEEF;
    localparam int          CmpAt  = P + D + 1;
    localparam int          DoneAt = P + D + 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] misr  = '0;
    logic        test_mode, seed_load, lfsr_en, misr_clear, misr_en, done, go;
    logic [6:0]  act;
`ifdef LBIST_SIG_OUT_EN
    logic [31:0] sig;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Model: pos = -1 idle, 0 seed/clear, 1..P patterns, P+1..P+D flush, CmpAt compare, DoneAt done.
    int          pos      = -1;
    bit          mstart_q = 1'b0;
    bit          mpass    = 1'b0;
    logic [31:0] msig     = '0;

    lbist_ctrl #(
        .PATTERN_CNT(P),
        .PIPE_DEPTH (D),
        .SIG_W      (32),
        .GOLDEN_SIG (Golden)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .start_i         (start),
        .misr_sig_i      (misr),
        .test_mode_o     (test_mode),
        .lfsr_seed_load_o(seed_load),
        .lfsr_en_o       (lfsr_en),
        .misr_clear_o    (misr_clear),
        .misr_en_o       (misr_en),
`ifdef LBIST_SIG_OUT_EN
        .sig_o           (sig),
`endif
        .done_o          (done),
        .go_nogo_o       (go)
    );

    always #5 clk = ~clk;

    assign act = {test_mode, seed_load, lfsr_en, misr_clear, misr_en, done, go};

    function automatic logic [6:0] exp_outs();
        logic [6:0] e;
        e[6] = (pos >= 0) && (pos <= CmpAt);
        e[5] = (pos == 0);
        e[4] = (pos >= 1) && (pos <= P);
        e[3] = (pos == 0);
        e[2] = (pos >= 1) && (pos <= P + D);
        e[1] = (pos == DoneAt);
        e[0] = (pos == DoneAt) && mpass;
        return e;
    endfunction

    task automatic model_reset();
        pos      = -1;
        mstart_q = 1'b0;
        mpass    = 1'b0;
        msig     = '0;
    endtask

    task automatic model_step();
        if (pos == CmpAt) begin
            mpass = (misr == Golden);
            msig  = misr;
        end
        if (pos < 0) begin
            if (start && !mstart_q) pos = 0;
        end else if (!start) begin
            pos = -1;
        end else if (pos < DoneAt) begin
            pos++;
        end
        mstart_q = start;
    endtask

    // One clock: model follows the sampling edge, outputs are observed on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        if (act !== 7'b0) begin
            miscompares++;
            $display("FAIL reset outputs act=%b exp=%b", act, 7'b0);
        end
        vectors++;
    endtask

    task automatic test_pass_run();
        int k = -1, first_done = -1, nl = 0, nm = 0;
        start = 1'b1;
        misr  = Golden;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            k++;
            if (act !== exp_outs()) begin
                miscompares++;
                $display("FAIL pass_run cyc %0d act=%b exp=%b", k, act, exp_outs());
            end
            vectors++;
            if (lfsr_en) nl++;
            if (misr_en) nm++;
            if (done && first_done < 0) first_done = k;
        end
        if (nl != P || nm != P + D) begin
            miscompares++;
            $display("FAIL pass_run enables lfsr=%0d misr=%0d exp %0d/%0d", nl, nm, P, P + D);
        end
        vectors++;
        if (first_done != DoneAt || go !== 1'b1) begin
            miscompares++;
            $display("FAIL pass_run latency=%0d go=%b exp %0d/1", first_done, go, DoneAt);
        end
        vectors++;
        start = 1'b0;
        tick();
        if (act !== exp_outs()) begin
            miscompares++;
            $display("FAIL pass_run idle act=%b exp=%b", act, exp_outs());
        end
        vectors++;
`ifdef LBIST_SIG_OUT_EN
        if (sig !== Golden) begin
            miscompares++;
            $display("FAIL sig_hold act=%h exp=%h", sig, Golden);
        end
        vectors++;
`endif
    endtask

    task automatic test_fail_run();
        bit seen = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 30 && !seen; i++) begin
            misr = (pos == CmpAt) ? 32'hDEADBEEE : $urandom;
            tick();
            if (act !== exp_outs()) begin
                miscompares++;
                $display("FAIL fail_run cyc %0d act=%b exp=%b", i, act, exp_outs());
            end
            vectors++;
            if (done) seen = 1'b1;
        end
        if (!seen || {done, go} !== 2'b10) begin
            miscompares++;
            $display("FAIL fail_run verdict done/go=%b%b exp 10", done, go);
        end
        vectors++;
        start = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        int k = -1, first_done = -1;
        bit done_seen = 1'b0;
        start = 1'b1;
        misr  = Golden;
        for (int i = 0; i < 10 && pos != 4; i++) begin
            tick();
            if (act !== exp_outs()) begin
                miscompares++;
                $display("FAIL abort_lead cyc %0d act=%b exp=%b", i, act, exp_outs());
            end
            vectors++;
        end
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (act !== 7'b0 || pos != -1) begin
                miscompares++;
                $display("FAIL abort_idle cyc %0d act=%b exp=%b", i, act, 7'b0);
            end
            vectors++;
            if (done) done_seen = 1'b1;
        end
        if (done_seen) begin
            miscompares++;
            $display("FAIL abort_done act=1 exp=0");
        end
        vectors++;
        start = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            k++;
            if (act !== exp_outs()) begin
                miscompares++;
                $display("FAIL abort_rerun cyc %0d act=%b exp=%b", k, act, exp_outs());
            end
            vectors++;
            if (done && first_done < 0) first_done = k;
        end
        if (first_done != DoneAt) begin
            miscompares++;
            $display("FAIL abort_latency act=%0d exp=%0d", first_done, DoneAt);
        end
        vectors++;
        start = 1'b0;
        tick();
    endtask

    task automatic test_hold_retrigger();
        int seeds = 0;
        start = 1'b1;
        misr  = Golden;
        for (int i = 0; i < 20 && !done; i++) tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (act !== exp_outs() || !done) begin
                miscompares++;
                $display("FAIL hold cyc %0d act=%b exp=%b", i, act, exp_outs());
            end
            vectors++;
            if (seed_load) seeds++;
        end
        if (seeds != 0) begin
            miscompares++;
            $display("FAIL hold_retrigger seeds=%0d exp=0", seeds);
        end
        vectors++;
        start = 1'b0;
        tick();
        start = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (act !== exp_outs()) begin
                miscompares++;
                $display("FAIL retrigger cyc %0d act=%b exp=%b", i, act, exp_outs());
            end
            vectors++;
            if (seed_load) seeds++;
        end
        if (seeds != 1 || !done) begin
            miscompares++;
            $display("FAIL retrigger seeds=%0d done=%b exp 1/1", seeds, done);
        end
        vectors++;
        start = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        int k = -1, first_done = -1, nl = 0;
        start = 1'b1;
        misr  = Golden;
        for (int i = 0; i < 20 && pos != P + 1; i++) tick();
        if (!misr_en || lfsr_en) begin
            miscompares++;
            $display("FAIL areset_settle misr_en=%b lfsr_en=%b exp 1/0", misr_en, lfsr_en);
        end
        vectors++;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        if (act !== 7'b0) begin
            miscompares++;
            $display("FAIL areset_immediate act=%b exp=%b", act, 7'b0);
        end
        vectors++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            k++;
            if (act !== exp_outs()) begin
                miscompares++;
                $display("FAIL areset_rerun cyc %0d act=%b exp=%b", k, act, exp_outs());
            end
            vectors++;
            if (lfsr_en) nl++;
            if (done && first_done < 0) first_done = k;
        end
        if (first_done != DoneAt || nl != P) begin
            miscompares++;
            $display("FAIL areset_latency act=%0d/%0d exp=%0d/%0d", first_done, nl, DoneAt, P);
        end
        vectors++;
        start = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) start = ~start;
            misr = (pos == CmpAt && $urandom_range(0, 1) == 1) ? Golden : $urandom;
            tick();
            if (act !== exp_outs()) begin
                miscompares++;
                $display("FAIL random cyc %0d act=%b exp=%b pos=%0d", i, act, exp_outs(), pos);
            end
            vectors++;
`ifdef LBIST_SIG_OUT_EN
            if (sig !== msig) begin
                miscompares++;
                $display("FAIL random_sig cyc %0d act=%h exp=%h", i, sig, msig);
            end
            vectors++;
`endif
        end
    endtask

    initial begin
        test_reset();
        test_pass_run();
        test_fail_run();
        test_abort();
        test_hold_retrigger();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
